// File: rtl/k12a_loader.sv
// Boot loader: holds the CPU in reset, streams source bytes into memory from LOAD_BASE upward
// with a setup/strobe/hold write cycle per byte, then releases the CPU.
module k12a_loader #(
    parameter logic [15:0] LOAD_BASE      = 16'h0000,
    parameter int          QUIESCE_CYCLES = 2
) (
    input  logic        cpu_clock,
    input  logic        reset_n,
    input  logic        load_req,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        cpu_reset_n,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        async_write,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] count
);

    typedef enum logic [2:0] {
        IDLE,
        QUIESCE,
        READY,
        SETUP,
        STROBE,
        HOLD,
        RELEASE
    } state_t;

    state_t      state, state_nx;
    logic [15:0] qcnt;
    logic [7:0]  data_q;

    // control strobes from the FSM to the datapath
    logic start, qdec, accept, advance;
    logic bus_phase, strobe_phase;

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        byte_ready   = 1'b0;
        cpu_reset_n  = 1'b0;
        busy         = 1'b1;
        bus_phase    = 1'b0;
        strobe_phase = 1'b0;
        start        = 1'b0;
        qdec         = 1'b0;
        accept       = 1'b0;
        advance      = 1'b0;
        case (state)
            IDLE: begin
                cpu_reset_n = 1'b1;
                busy        = 1'b0;
                if (load_req) begin
                    state_nx = QUIESCE;
                    start    = 1'b1;
                end
            end
            QUIESCE: begin
                if (!load_req)      state_nx = RELEASE;
                else if (qcnt == '0) state_nx = READY;
                else                qdec     = 1'b1;
            end
            READY: begin
                byte_ready = load_req;
                if (!load_req) state_nx = RELEASE;
                else if (byte_valid) begin
                    accept   = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                bus_phase = 1'b1;
                state_nx  = STROBE;
            end
            STROBE: begin
                bus_phase    = 1'b1;
                strobe_phase = 1'b1;
                state_nx     = HOLD;
            end
            // a request drop mid-write is noticed back in READY, so the write always finishes
            HOLD: begin
                bus_phase = 1'b1;
                advance   = 1'b1;
                state_nx  = READY;
            end
            RELEASE: begin
                cpu_reset_n = 1'b1;
                state_nx    = IDLE;
            end
            default: begin
                cpu_reset_n = 1'b1;
                busy        = 1'b0;
                state_nx    = IDLE;
            end
        endcase

        // once the address has wrapped, bytes are still consumed but never reach memory
        mem_enable  = bus_phase & ~overflow;
        mem_write   = bus_phase & ~overflow;
        async_write = strobe_phase & ~overflow;
        mem_data    = mem_enable ? data_q : 8'h00;
    end

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            qcnt     <= '0;
            data_q   <= '0;
            mem_addr <= LOAD_BASE;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (start) begin
                qcnt     <= 16'(QUIESCE_CYCLES - 1);
                mem_addr <= LOAD_BASE;
                count    <= '0;
                overflow <= 1'b0;
            end
            if (qdec)   qcnt   <= qcnt - 16'd1;
            if (accept) data_q <= byte_data;
            if (advance) begin
                mem_addr <= mem_addr + 16'd1;
                if (count != 16'hFFFF)    count    <= count + 16'd1;
                if (mem_addr == 16'hFFFF) overflow <= 1'b1;
            end
        end
    end

endmodule
